// File: rtl/conv_pkg.sv
// Shared definitions for the convolution pipeline: pixel width, fill FSM encoding,
// and the number of FILTER_SIZE-row buffers a frame produces.
package conv_pkg;

  localparam int PIX_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRIME = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_SLIDE = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  function automatic int n_buf(input int image_height, input int filter_size);
    return image_height - filter_size + 1;
  endfunction

endpackage

// File: rtl/row_line_reg.sv
// One image row of pixels: per-column write, whole-row parallel load, and a full flag
// that is set by the write into the last column.
module row_line_reg
  import conv_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [$clog2(WIDTH)-1:0] col,
  input  logic [PIX_W-1:0]         pix,
  input  logic                     load_en,
  input  logic [WIDTH*PIX_W-1:0]   load_data,
  output logic [WIDTH*PIX_W-1:0]   data,
  output logic                     full
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (load_en) begin
        data <= load_data;
      end else if (wr_en) begin
        data[int'(col)*PIX_W +: PIX_W] <= pix;
      end
      if (clr) begin
        full <= 1'b0;
      end else if (wr_en && col == LAST_COL) begin
        full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/row_buffer_fill.sv
// Assembles a raster pixel stream into a FILTER_SIZE-row window buffer plus one staging
// row, and hands each fresh buffer to the window shifter via shift_en / shift_buffer.
module row_buffer_fill
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128,
  parameter int FILTER_SIZE  = 3
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [PIX_W-1:0]                         pix_in,
  input  logic                                     pix_valid,
  output logic                                     pix_ready,
  input  logic                                     new_buffer,
  output logic [FILTER_SIZE*IMAGE_WIDTH*PIX_W-1:0] row_buffer_out,
  output logic                                     shift_en,
  output logic                                     shift_buffer,
  output logic                                     frame_done
);

  localparam int ROW_BITS = IMAGE_WIDTH * PIX_W;
  localparam int CW       = $clog2(IMAGE_WIDTH);
  localparam int RW       = $clog2(IMAGE_HEIGHT + 1);
  localparam int NB       = n_buf(IMAGE_HEIGHT, FILTER_SIZE);
  localparam int BW       = $clog2(NB + 1);

  localparam logic [CW-1:0] LAST_COL   = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] LAST_PRIME = RW'(FILTER_SIZE - 1);
  localparam logic [RW-1:0] ALL_ROWS   = RW'(IMAGE_HEIGHT);
  localparam logic [BW-1:0] LAST_BUF   = BW'(NB - 1);

  logic [2:0]    state, state_n;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] rows_in, rows_in_n;
  logic [BW-1:0] buf_cnt;
  logic          ready_n;

  // Index FILTER_SIZE is the staging row; 0..FILTER_SIZE-1 are the visible rows.
  logic [ROW_BITS-1:0]    row_q [FILTER_SIZE+1];
  logic [FILTER_SIZE:0]   row_full;
  logic [FILTER_SIZE-1:0] row_sel;

  logic xfer, col_last, start_frame, fill_state, prime_wr, stg_wr, slide, nb_take;
  logic stg_full, stg_full_n;

  // Handshake: a pixel moves when pix_valid && pix_ready at a rising edge. pix_ready is a
  // register derived from next-cycle state, so it falls in the cycle after the transfer
  // that fills staging and never depends combinationally on pix_valid.
  assign xfer        = pix_valid & pix_ready;
  assign col_last    = (col_cnt == LAST_COL);
  assign start_frame = (state == ST_IDLE) & start;
  assign fill_state  = (state == ST_ARM) | (state == ST_RUN) | (state == ST_WAIT);
  assign prime_wr    = xfer & (state == ST_PRIME);
  assign stg_wr      = xfer & fill_state;
  assign slide       = (state == ST_SLIDE);
  assign nb_take     = (state == ST_RUN) & new_buffer;
  assign stg_full    = row_full[FILTER_SIZE];

  assign shift_en     = (state == ST_ARM);
  assign shift_buffer = (state == ST_RUN);
  assign frame_done   = (state == ST_DONE);

  // Staging counts as full in the same cycle its last pixel lands.
  always_comb begin
    stg_full_n = stg_full;
    if (start_frame || slide) begin
      stg_full_n = 1'b0;
    end else if (stg_wr && col_last) begin
      stg_full_n = 1'b1;
    end
  end

  always_comb begin
    rows_in_n = rows_in;
    if (start_frame) begin
      rows_in_n = '0;
    end else if (xfer && col_last) begin
      rows_in_n = rows_in + RW'(1);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_PRIME;
      ST_PRIME: if (prime_wr && col_last && rows_in == LAST_PRIME) state_n = ST_ARM;
      ST_ARM:   state_n = ST_RUN;
      ST_RUN: begin
        if (new_buffer) begin
          if (buf_cnt == LAST_BUF)  state_n = ST_DONE;
          else if (stg_full_n)      state_n = ST_SLIDE;
          else                      state_n = ST_WAIT;
        end
      end
      ST_WAIT:  if (stg_full_n) state_n = ST_SLIDE;
      ST_SLIDE: state_n = ST_ARM;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_n = 1'b0;
    if (state_n == ST_PRIME) begin
      ready_n = 1'b1;
    end else if (state_n == ST_ARM || state_n == ST_RUN || state_n == ST_WAIT) begin
      ready_n = ~stg_full_n & (rows_in_n < ALL_ROWS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      col_cnt   <= '0;
      rows_in   <= '0;
      buf_cnt   <= '0;
      pix_ready <= 1'b0;
    end else begin
      state     <= state_n;
      rows_in   <= rows_in_n;
      pix_ready <= ready_n;
      if (start_frame) begin
        col_cnt <= '0;
      end else if (xfer) begin
        col_cnt <= col_last ? '0 : col_cnt + CW'(1);
      end
      if (start_frame) begin
        buf_cnt <= '0;
      end else if (nb_take) begin
        buf_cnt <= buf_cnt + BW'(1);
      end
    end
  end

  // During PRIME the target is the topmost row not yet full; SLIDE shifts every row up
  // by one, with the staging row entering at the bottom.
  for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
    if (r == 0) begin : g_first
      assign row_sel[r] = ~row_full[r];
    end else begin : g_next
      assign row_sel[r] = ~row_full[r] & row_full[r-1];
    end

    row_line_reg #(.WIDTH(IMAGE_WIDTH)) u_row (
      .clk       (clk),
      .rst       (rst),
      .clr       (start_frame),
      .wr_en     (prime_wr & row_sel[r]),
      .col       (col_cnt),
      .pix       (pix_in),
      .load_en   (slide),
      .load_data (row_q[r+1]),
      .data      (row_q[r]),
      .full      (row_full[r])
    );

    assign row_buffer_out[r*ROW_BITS +: ROW_BITS] = row_q[r];
  end

  row_line_reg #(.WIDTH(IMAGE_WIDTH)) u_stage (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_frame | slide),
    .wr_en     (stg_wr),
    .col       (col_cnt),
    .pix       (pix_in),
    .load_en   (1'b0),
    .load_data ('0),
    .data      (row_q[FILTER_SIZE]),
    .full      (row_full[FILTER_SIZE])
  );

endmodule

// File: tb/tb_row_buffer_fill.sv
// Bench for row_buffer_fill on a 9x9 image with a 3-row window.
module tb_row_buffer_fill;

  localparam int W     = 9;
  localparam int H     = 9;
  localparam int FS    = 3;
  localparam int N_BUF = H - FS + 1;
  localparam int BUF_W = FS * W * 8;

  logic             clk, rst, start, pix_valid, pix_ready, new_buffer;
  logic             shift_en, shift_buffer, frame_done;
  logic [7:0]       pix_in;
  logic [BUF_W-1:0] row_buffer_out;

  int               n_tests, n_fail;
  logic [BUF_W-1:0] exp_q[$];
  logic [7:0]       pix_mem [W*H];
  int               se_count, fd_count, leak;
  logic             shifter_done;
  logic             prev_se, prev_sb;
  logic [BUF_W-1:0] prev_buf;

  typedef struct {
    logic start;
    logic nb;
    logic rdy;
    logic se;
    logic sb;
    logic fd;
  } vec_t;
  vec_t vec [5];

  row_buffer_fill #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FILTER_SIZE(FS)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pix_in         (pix_in),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .new_buffer     (new_buffer),
    .row_buffer_out (row_buffer_out),
    .shift_en       (shift_en),
    .shift_buffer   (shift_buffer),
    .frame_done     (frame_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checkers ----------------
  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_buf(input string name, input logic [BUF_W-1:0] act,
                           input logic [BUF_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BUF_W-1:0] make_buf(input int top);
    logic [BUF_W-1:0] b;
    b = '0;
    for (int r = 0; r < FS; r++)
      for (int c = 0; c < W; c++)
        b[(r*W+c)*8 +: 8] = pix_mem[(top+r)*W+c];
    return b;
  endfunction

  // Scoreboard side: every shift_en pops the next expected buffer.
  always @(negedge clk) begin
    if (!rst) begin
      if (shift_en) begin
        se_count++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL buf_unexpected: shift_en with no expected buffer queued");
        end else begin
          check_buf("buf_contents", row_buffer_out, exp_q.pop_front());
        end
        check_bit("shift_en_one_cycle", prev_se, 1'b0);
      end
      if (frame_done) fd_count++;
      check_bit("se_sb_exclusive", shift_en & shift_buffer, 1'b0);
      if (shift_buffer && prev_sb) check_buf("buf_stable", row_buffer_out, prev_buf);
    end
    prev_se  = shift_en;
    prev_sb  = shift_buffer;
    prev_buf = row_buffer_out;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] val);
    logic got;
    got       = 1'b0;
    pix_valid = 1'b1;
    pix_in    = val;
    for (int t = 0; t < 200 && !got; t++) begin
      got = pix_ready;
      step();
    end
    pix_valid = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL pix_timeout: pixel %0d never accepted", val);
    end
  endtask

  task automatic check_ctl(input string name, input logic se, input logic sb);
    check_bit({name, "_se"}, shift_en, se);
    check_bit({name, "_sb"}, shift_buffer, sb);
  endtask

  task automatic producer();
    for (int p = 0; p < W*H; p++) begin
      repeat ($urandom_range(0, 2)) step();
      if ((p % W) == W-1 && (p / W) >= FS-1) exp_q.push_back(make_buf(p / W - (FS-1)));
      send_pix(pix_mem[p]);
    end
    for (int t = 0; t < 3000 && !shifter_done; t++) begin
      if (pix_ready) leak++;
      step();
    end
  endtask

  task automatic shifter();
    for (int k = 0; k < N_BUF; k++) begin
      int t;
      t = 0;
      while (!shift_en && t < 3000) begin
        step();
        t++;
      end
      check_bit("shifter_armed", shift_en, 1'b1);
      if (!shift_en) break;
      // Stray pulse during ARM must not count as a consumed buffer.
      new_buffer = 1'b1;
      step();
      new_buffer = 1'b0;
      check_bit("arm_nb_ignored", shift_buffer, 1'b1);
      repeat ($urandom_range(2, 12)) step();
      new_buffer = 1'b1;
      step();
      new_buffer = 1'b0;
      if (k == N_BUF-1) begin
        check_bit("frame_done_pulse", frame_done, 1'b1);
        step();
        check_bit("frame_done_clear", frame_done, 1'b0);
      end
    end
    shifter_done = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0; n_fail = 0; se_count = 0; fd_count = 0; leak = 0;
    shifter_done = 1'b0;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0; new_buffer = 1'b0;
    repeat (2) step();
    check_bit("rst_ready", pix_ready, 1'b0);
    check_ctl("rst", 1'b0, 1'b0);
    check_bit("rst_done", frame_done, 1'b0);
    check_buf("rst_buf", row_buffer_out, '0);
    rst = 1'b0;
    step();

    // IDLE ignores new_buffer; start enters PRIME; start in PRIME is ignored.
    vec[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      start      = vec[i].start;
      new_buffer = vec[i].nb;
      step();
      check_bit("vec_ready", pix_ready, vec[i].rdy);
      check_ctl("vec", vec[i].se, vec[i].sb);
      check_bit("vec_done", frame_done, vec[i].fd);
    end
    start = 1'b0;
    new_buffer = 1'b0;

    // Partial PRIME, then reset aborts it.
    for (int i = 0; i < 5; i++) send_pix(8'(100 + i));
    for (int i = 0; i < 5; i++) check_int("prime_byte", int'(row_buffer_out[i*8 +: 8]), 100 + i);
    rst = 1'b1;
    step();
    check_buf("midprime_rst_buf", row_buffer_out, '0);
    check_bit("midprime_rst_ready", pix_ready, 1'b0);
    check_ctl("midprime_rst", 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // Prime the window with pixels 0..26.
    for (int p = 0; p < W*H; p++) pix_mem[p] = 8'(p);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int p = 0; p < FS*W; p++) begin
      if (p == FS*W-1) exp_q.push_back(make_buf(0));
      send_pix(pix_mem[p]);
    end
    check_ctl("prime_arm", 1'b1, 1'b0);
    step();
    check_ctl("prime_run", 1'b0, 1'b1);

    // Staging fills under shift_buffer, then new_buffer slides.
    for (int p = 27; p < 36; p++) begin
      if (p == 35) exp_q.push_back(make_buf(1));
      send_pix(pix_mem[p]);
    end
    check_bit("stage_full_ready", pix_ready, 1'b0);
    new_buffer = 1'b1;
    step();
    new_buffer = 1'b0;
    check_ctl("slide", 1'b0, 1'b0);
    step();
    check_ctl("slide_arm_2cyc", 1'b1, 1'b0);
    step();
    check_ctl("slide_run", 1'b0, 1'b1);

    // new_buffer before staging is ready: WAIT until the row completes.
    new_buffer = 1'b1;
    step();
    new_buffer = 1'b0;
    check_ctl("wait_enter", 1'b0, 1'b0);
    repeat (2) step();
    check_ctl("wait_hold", 1'b0, 1'b0);
    check_bit("wait_ready", pix_ready, 1'b1);
    for (int p = 36; p < 45; p++) begin
      if (p == 44) exp_q.push_back(make_buf(2));
      send_pix(pix_mem[p]);
    end
    check_ctl("wait_slide", 1'b0, 1'b0);
    step();
    check_ctl("wait_arm", 1'b1, 1'b0);
    step();
    check_ctl("wait_run", 1'b0, 1'b1);

    // new_buffer coincident with the last staging pixel goes straight to SLIDE.
    for (int p = 45; p < 53; p++) send_pix(pix_mem[p]);
    exp_q.push_back(make_buf(3));
    check_bit("same_cycle_ready", pix_ready, 1'b1);
    pix_valid  = 1'b1;
    pix_in     = pix_mem[53];
    new_buffer = 1'b1;
    step();
    pix_valid  = 1'b0;
    new_buffer = 1'b0;
    check_ctl("same_cycle_slide", 1'b0, 1'b0);
    step();
    check_ctl("same_cycle_arm", 1'b1, 1'b0);
    step();
    check_ctl("same_cycle_run", 1'b0, 1'b1);
    check_int("queue_drained_partial", exp_q.size(), 0);

    // Reset mid-frame: no frame_done, everything cleared.
    rst = 1'b1;
    step();
    check_buf("abort_buf", row_buffer_out, '0);
    check_ctl("abort", 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_int("abort_no_done", fd_count, 0);

    // Full frame with random pixels, random gaps and a shifter model.
    for (int p = 0; p < W*H; p++) pix_mem[p] = 8'($urandom_range(0, 255));
    se_count = 0;
    fd_count = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    fork
      producer();
      shifter();
    join
    repeat (3) step();
    check_int("frame_shift_en_count", se_count, N_BUF);
    check_int("frame_done_count", fd_count, 1);
    check_int("ready_after_last_pixel", leak, 0);
    check_int("queue_drained_frame", exp_q.size(), 0);
    check_bit("idle_ready", pix_ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
